// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit CPU control path.
//   - opcode constants (OP_NOP .. OP_HLT)
//   - instruction field bit positions
//   - ALU operation codes shared with the ALU
//   - FSM state encoding and decoded opcode classes
package cpu_pkg;

   // Opcodes (instruction bits [15:12])
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_LDI = 4'h6;
   localparam logic [3:0] OP_LD  = 4'h7;
   localparam logic [3:0] OP_ST  = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Instruction field bit positions
   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RA_HI  = 8;
   localparam int RA_LO  = 6;
   localparam int RB_HI  = 5;
   localparam int RB_LO  = 3;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   // ALU operation codes; numerically equal to op[2:0] of the ALU opcodes
   localparam logic [2:0] ALU_NOP = 3'd0;
   localparam logic [2:0] ALU_ADD = 3'd1;
   localparam logic [2:0] ALU_SUB = 3'd2;
   localparam logic [2:0] ALU_AND = 3'd3;
   localparam logic [2:0] ALU_OR  = 3'd4;
   localparam logic [2:0] ALU_XOR = 3'd5;

   // Control FSM states; IDLE is 0 so the reset value of the debug view is 0
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   // Decoded instruction class
   typedef enum logic [3:0] {
      CLS_NOP = 4'd0,
      CLS_ALU = 4'd1,
      CLS_LDI = 4'd2,
      CLS_LD  = 4'd3,
      CLS_ST  = 4'd4,
      CLS_JZ  = 4'd5,
      CLS_JMP = 4'd6,
      CLS_HLT = 4'd7,
      CLS_ILL = 4'd8
   } op_class_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: purely combinational instruction decoder.
// Ports:
//   ir        in  16  instruction register contents
//   op_class  out     decoded class (alu/ldi/ld/st/jz/jmp/hlt/nop/illegal)
//   rd/ra/rb  out  3  register fields
//   alu_op    out  3  ALU code for ADD..XOR, ALU_NOP otherwise
//   imm       out  8  immediate field
module cpu_ctrl_decode
   import cpu_pkg::*;
(
   input  logic [15:0] ir,
   output op_class_t   op_class,
   output logic [2:0]  rd,
   output logic [2:0]  ra,
   output logic [2:0]  rb,
   output logic [2:0]  alu_op,
   output logic [7:0]  imm
);

   logic [3:0] op;

   assign op  = ir[OP_HI:OP_LO];
   assign rd  = ir[RD_HI:RD_LO];
   assign ra  = ir[RA_HI:RA_LO];
   assign rb  = ir[RB_HI:RB_LO];
   assign imm = ir[IMM_HI:IMM_LO];

   always_comb begin
      op_class = CLS_ILL;
      alu_op   = ALU_NOP;
      case (op)
         OP_NOP: op_class = CLS_NOP;
         OP_ADD: begin op_class = CLS_ALU; alu_op = ALU_ADD; end
         OP_SUB: begin op_class = CLS_ALU; alu_op = ALU_SUB; end
         OP_AND: begin op_class = CLS_ALU; alu_op = ALU_AND; end
         OP_OR:  begin op_class = CLS_ALU; alu_op = ALU_OR;  end
         OP_XOR: begin op_class = CLS_ALU; alu_op = ALU_XOR; end
         OP_LDI: op_class = CLS_LDI;
         OP_LD:  op_class = CLS_LD;
         OP_ST:  op_class = CLS_ST;
         OP_JZ:  op_class = CLS_JZ;
         OP_JMP: op_class = CLS_JMP;
         OP_HLT: op_class = CLS_HLT;
         default: op_class = CLS_ILL;   // opcodes B..E
      endcase
   end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle control unit for the 16-bit CPU.
// Sequences FETCH -> EXEC -> (MEM) -> (WB), runs the RAM request
// handshake with a bus-error timeout, and generates datapath strobes.
//
// Handshake: en_ram_in is held high for every cycle spent in FETCH or MEM;
// the RAM signals completion with en_ram_out in the same cycle that `ins`
// is valid. The request is considered accepted in any cycle where both are
// high, and the FSM leaves the access state on the following edge, so
// en_ram_in drops one cycle after completion unless the next state is
// again an access state (MEM(ST) -> FETCH). en_ram_out is ignored in all
// other states.
//
// Ports:
//   clk, rst (async, active low), en_in (run enable)
//   en_ram_out, ins          RAM completion and data
//   zero                     datapath zero flag for JZ
//   en_ram_in, ram_we, addr_sel         RAM request controls
//   ir_ld, pc_inc, pc_ld                IR / PC strobes
//   alu_op, imm_sel, mem_sel            ALU op and write-back source select
//   rf_we, rf_wa, rf_ra, rf_rb, imm     register-file controls and immediate
//   halted, bus_err, illegal            status
//   state_dbg                           current FSM state
// TIMEOUT must be >= 1 and 2**TW must exceed TIMEOUT.
module cpu_ctrl
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int TW      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_in,
   input  logic        en_ram_out,
   input  logic [15:0] ins,
   input  logic        zero,
   output logic        en_ram_in,
   output logic        ram_we,
   output logic        addr_sel,
   output logic        ir_ld,
   output logic        pc_inc,
   output logic        pc_ld,
   output logic [2:0]  alu_op,
   output logic        imm_sel,
   output logic        mem_sel,
   output logic        rf_we,
   output logic [2:0]  rf_wa,
   output logic [2:0]  rf_ra,
   output logic [2:0]  rf_rb,
   output logic [7:0]  imm,
   output logic        halted,
   output logic        bus_err,
   output logic        illegal,
   output logic [2:0]  state_dbg
);

   // The access gives up once the counter has seen TIMEOUT-1 idle cycles and
   // the current one is idle too, i.e. after TIMEOUT unanswered request cycles.
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

   state_t      state, next_state;
   logic [15:0] ir;
   logic [TW-1:0] wait_cnt;
   op_class_t   op_class;
   logic [2:0]  rd;
   logic        wait_expired;
   state_t      boundary_state;

   cpu_ctrl_decode u_decode (
      .ir       (ir),
      .op_class (op_class),
      .rd       (rd),
      .ra       (rf_ra),
      .rb       (rf_rb),
      .alu_op   (alu_op),
      .imm      (imm)
   );

   assign rf_wa          = rd;
   assign state_dbg      = state;
   assign wait_expired   = (wait_cnt == WAIT_LAST) && !en_ram_out;
   // run enable is only consulted between instructions
   assign boundary_state = en_in ? S_FETCH : S_IDLE;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   // Instruction register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       ir <= '0;
      else if (ir_ld) ir <= ins;
   end

   // Wait counter: cleared whenever the state changes (so on every entry to
   // FETCH or MEM, including MEM -> FETCH), counts unanswered access cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wait_cnt <= '0;
      else if (next_state != state)
         wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !en_ram_out)
         wait_cnt <= wait_cnt + TW'(1);
   end

   // Next state and strobes
   always_comb begin
      next_state = state;
      en_ram_in  = 1'b0;
      ram_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_ld      = 1'b0;
      pc_inc     = 1'b0;
      pc_ld      = 1'b0;
      imm_sel    = 1'b0;
      mem_sel    = 1'b0;
      rf_we      = 1'b0;
      halted     = 1'b0;
      bus_err    = 1'b0;
      illegal    = 1'b0;

      case (state)
         S_IDLE: begin
            if (en_in) next_state = S_FETCH;
         end

         S_FETCH: begin
            en_ram_in = 1'b1;
            if (en_ram_out) begin
               ir_ld      = 1'b1;
               pc_inc     = 1'b1;
               next_state = S_EXEC;
            end else if (wait_expired) begin
               next_state = S_ERR;
            end
         end

         S_EXEC: begin
            case (op_class)
               CLS_ALU, CLS_LDI: next_state = S_WB;
               CLS_LD, CLS_ST:   next_state = S_MEM;
               CLS_JZ: begin
                  pc_ld      = zero;
                  next_state = boundary_state;
               end
               CLS_JMP: begin
                  pc_ld      = 1'b1;
                  next_state = boundary_state;
               end
               CLS_HLT: next_state = S_HALT;
               CLS_ILL: begin
                  illegal    = 1'b1;
                  next_state = boundary_state;
               end
               default: next_state = boundary_state;   // NOP
            endcase
         end

         S_MEM: begin
            en_ram_in = 1'b1;
            addr_sel  = 1'b1;
            ram_we    = (op_class == CLS_ST);
            if (en_ram_out) begin
               next_state = (op_class == CLS_LD) ? S_WB : boundary_state;
            end else if (wait_expired) begin
               next_state = S_ERR;
            end
         end

         S_WB: begin
            rf_we      = 1'b1;
            mem_sel    = (op_class == CLS_LD);
            imm_sel    = (op_class == CLS_LDI);
            next_state = boundary_state;
         end

         S_HALT: halted  = 1'b1;
         S_ERR:  bus_err = 1'b1;

         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control unit for the 16-bit CPU. It sequences fetch, execute, memory and write-back, and drives the RAM read handshake (`en_ram_in` / `en_ram_out`). It also generates every register-file, ALU, PC and address-select strobe for the datapath. It sits inside `cpu`, between the instruction/RAM port and the datapath, and replaces ad-hoc enables with one FSM.

## Interface
- `TIMEOUT`, default 15: maximum wait cycles for `en_ram_out` before a bus error.
- `TW`, default 4: width of the wait counter; must satisfy 2^TW > TIMEOUT.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en_in`  in  1  run enable; sampled only at instruction boundaries.
- `en_ram_out`  in  1  RAM read/write done; `ins` is valid in this cycle.
- `ins`  in  16  RAM data: the instruction during fetch, load data during MEM.
- `zero`  in  1  datapath zero flag, captured from the previous ALU result.
- `en_ram_in`  out  1  RAM access request.
- `ram_we`  out  1  write qualifier for `en_ram_in`, high for ST.
- `addr_sel`  out  1  address source: 0 = PC, 1 = register `ra`.
- `ir_ld`  out  1  load the instruction register.
- `pc_inc`  out  1  PC increment.
- `pc_ld`  out  1  load PC from `imm`.
- `alu_op`  out  3  ALU operation code, equal to `op[2:0]` for opcodes 1–5.
- `imm_sel`  out  1  select `imm` as the write-back source.
- `mem_sel`  out  1  select RAM data as the write-back source.
- `rf_we`  out  1  register-file write enable.
- `rf_wa`  out  3  register-file write address.
- `rf_ra`  out  3  register-file read address A.
- `rf_rb`  out  3  register-file read address B.
- `imm`  out  8  immediate field.
- `halted`  out  1  core has executed HLT.
- `bus_err`  out  1  RAM access timed out.
- `illegal`  out  1  one-cycle pulse when an illegal opcode executes.

## Operation
- **Instruction fields** (held in an internal IR):
  - `op` = [15:12], `rd` = [11:9], `ra` = [8:6], `rb` = [5:3], `imm` = [7:0].
- **Opcodes:**
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR.
  - 6 LDI (rd ← imm); 7 LD (rd ← M[ra]); 8 ST (M[ra] ← rb).
  - 9 JZ (PC ← imm if `zero`); A JMP (PC ← imm); F HLT.
  - B–E are illegal: they execute as NOP and pulse `illegal` in EXEC.
- **States:** IDLE, FETCH, EXEC, MEM, WB, HALT, ERR.
- **Transitions:**
  - IDLE → FETCH when `en_in` = 1.
  - FETCH: `en_ram_in` = 1 and `addr_sel` = 0. When `en_ram_out` = 1, pulse `ir_ld` and `pc_inc`, then go to EXEC.
  - EXEC:
    - Opcodes 1–6 → WB.
    - LD/ST → MEM.
    - JZ/JMP pulse `pc_ld` (JZ only if `zero`), then take the boundary transition.
    - HLT → HALT.
    - NOP and illegal take the boundary transition.
  - MEM: `en_ram_in` = 1 and `addr_sel` = 1; `ram_we` = 1 for ST. On `en_ram_out`: LD → WB, ST → boundary.
  - WB: `rf_we` = 1 with `rf_wa` = rd; `mem_sel` for LD, `imm_sel` for LDI. Then take the boundary transition.
  - Boundary transition: `en_in` = 1 → FETCH, else → IDLE.
  - HALT: `halted` = 1; exited only by reset.
  - ERR: `bus_err` = 1; exited only by reset.
- **Timeout:** the wait counter clears on entry to FETCH or MEM and increments each cycle `en_ram_out` = 0. When it reaches `TIMEOUT` with no `en_ram_out`, go to ERR and drop `en_ram_in`.
- `en_ram_out` outside FETCH/MEM is ignored.
- `rf_ra`, `rf_rb`, `alu_op` and `imm` decode continuously from IR; they are stable from EXEC through WB.

## Timing
- All strobes are combinational from state + IR + `en_ram_out`; the state is registered. No glitch-sensitive path leaves the block.
- **Reset:** state = IDLE, IR = 0, counter = 0, and every output = 0.
- Reset may assert in any state, including mid-handshake; `en_ram_in` drops immediately (async).
- **Latency, zero-wait RAM** (`en_ram_out` high in the first request cycle):
  - ALU/LDI: 3 cycles.
  - LD: 4 cycles.
  - ST: 3 cycles.
  - JZ/JMP/NOP: 2 cycles.
- Each RAM wait cycle adds 1.
- **Handshake:** `en_ram_in` stays high continuously until the cycle `en_ram_out` is sampled high, inclusive, then drops the next cycle. Back-to-back accesses (MEM→FETCH) re-assert after one low cycle only if the next state is FETCH via WB; MEM(ST)→FETCH is allowed back-to-back.
- **Pulse widths:** `ir_ld`, `pc_inc`, `pc_ld`, `rf_we` and `illegal` are exactly one cycle per instruction.
- `en_in` deasserted mid-instruction never aborts it; the instruction completes, then the FSM goes to IDLE.

## Structure
- Package `cpu_pkg`:
  - opcode constants `OP_NOP` … `OP_HLT`;
  - state encoding;
  - field bit positions;
  - ALU op codes shared with the ALU.
- One sub-module `cpu_ctrl_decode`: combinational IR → opcode class (alu/ldi/ld/st/jz/jmp/hlt/illegal) plus field outputs.
- The FSM, wait counter and IR stay in `cpu_ctrl`.

## Test plan
1. **Reset and IDLE:** reset, `en_in` = 0 for 10 cycles → all outputs 0 and the FSM stays in IDLE.
2. **ADD, zero wait:** `en_in` = 1, `en_ram_out` = 1, `ins` = 16'h1250 → ADD rd=1, ra=1, rb=2.
   - `ir_ld` + `pc_inc` in cycle 1.
   - `alu_op` = 1 in cycle 2.
   - `rf_we` with `rf_wa` = 1 in cycle 3.
   - Next FETCH in cycle 4.
3. **LD with wait states:** `ins` = 16'h7A80 (LD r5, [r2]), `en_ram_out` delayed 3 cycles in MEM → `addr_sel` = 1 for 4 cycles, then `rf_we`, `mem_sel`, `rf_wa` = 5; total 7 cycles.
4. **Jumps:** `ins` = 16'h9042 with `zero` = 0 → no `pc_ld`. Same with `zero` = 1 → `pc_ld` and `imm` = 8'h42. `ins` = 16'hA0C2 → `pc_ld` and `imm` = 8'hC2.
5. **Timeout:** `en_ram_out` held 0 in FETCH → after 15 cycles, ERR, `bus_err` = 1, `en_ram_in` = 0. Reset clears to IDLE.
6. **HLT, illegal opcode, reset mid-MEM:**
   - `ins` = 16'hF000 → `halted` = 1 and no further `en_ram_in`.
   - `ins` = 16'hB000 → `illegal` pulse, then FETCH.
   - `rst` low during MEM → all outputs 0 asynchronously.
